// File: rtl/multicycle_control_if.sv
// Control bundle between the multi-cycle MIPS main control FSM and its datapath.
// The FSM drives through the master modport and the datapath uses the slave modport.
interface multicycle_control_if;
  logic [5:0] opcode_i;
  logic       mem_ready_i;
  logic       pc_write_o;
  logic       i_or_d_o;
  logic       mem_read_o;
  logic       mem_write_o;
  logic       ir_write_o;
  logic       reg_dst_o;
  logic       mem_to_reg_o;
  logic       reg_write_o;
  logic       alu_src_a_o;
  logic [1:0] alu_src_b_o;
  logic [2:0] alu_op_o;
  logic [1:0] pc_src_o;
  logic [3:0] state_o;
  logic       illegal_op_o;

  modport master (
    input  opcode_i, mem_ready_i,
    output pc_write_o, i_or_d_o, mem_read_o, mem_write_o, ir_write_o,
           reg_dst_o, mem_to_reg_o, reg_write_o, alu_src_a_o, alu_src_b_o,
           alu_op_o, pc_src_o, state_o, illegal_op_o
  );

  modport slave (
    output opcode_i, mem_ready_i,
    input  pc_write_o, i_or_d_o, mem_read_o, mem_write_o, ir_write_o,
           reg_dst_o, mem_to_reg_o, reg_write_o, alu_src_a_o, alu_src_b_o,
           alu_op_o, pc_src_o, state_o, illegal_op_o
  );
endinterface

// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle MIPS datapath: sequences fetch/decode/execute/
// memory/write-back and decodes every strobe and mux select from the current state.
module multicycle_control (
  input  logic                  clk,
  input  logic                  reset,
  multicycle_control_if.master  bus
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_RD    = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WR    = 4'd5,
    S_EXEC_R    = 4'd6,
    S_WB_R      = 4'd7,
    S_EXEC_ADDI = 4'd8,
    S_EXEC_ORI  = 4'd9,
    S_WB_I      = 4'd10,
    S_JUMP      = 4'd11
  } state_e;

  state_e     state_q, state_d;

  logic       pc_write, i_or_d, mem_read, mem_write, ir_write;
  logic       reg_dst, mem_to_reg, reg_write, alu_src_a, illegal_op;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_op;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Outputs are decoded from state; reset gates them so nothing fires while held.
  always_comb begin
    state_d    = S_FETCH;
    pc_write   = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 3'b000;
    pc_src     = 2'b00;
    illegal_op = 1'b0;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          alu_op    = 3'b100;
          ir_write  = bus.mem_ready_i;
          pc_write  = bus.mem_ready_i;
          state_d   = bus.mem_ready_i ? S_DECODE : S_FETCH;
        end
        S_DECODE: begin
          alu_src_b = 2'b11;
          alu_op    = 3'b100;
          case (bus.opcode_i)
            OP_LW, OP_SW: state_d = S_MEM_ADDR;
            OP_RTYPE:     state_d = S_EXEC_R;
            OP_ADDI:      state_d = S_EXEC_ADDI;
            OP_ORI:       state_d = S_EXEC_ORI;
            OP_J:         state_d = S_JUMP;
            default: begin
              illegal_op = 1'b1;
              state_d    = S_FETCH;
            end
          endcase
        end
        S_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          alu_op    = 3'b100;
          if (bus.opcode_i == OP_LW)      state_d = S_MEM_RD;
          else if (bus.opcode_i == OP_SW) state_d = S_MEM_WR;
          else                            state_d = S_FETCH;
        end
        S_MEM_RD: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
          state_d  = bus.mem_ready_i ? S_MEM_WB : S_MEM_RD;
        end
        S_MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        S_MEM_WR: begin
          mem_write = 1'b1;
          i_or_d    = 1'b1;
          state_d   = bus.mem_ready_i ? S_FETCH : S_MEM_WR;
        end
        S_EXEC_R: begin
          alu_src_a = 1'b1;
          alu_op    = 3'b111;
          state_d   = S_WB_R;
        end
        S_WB_R: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
        end
        S_EXEC_ADDI: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          alu_op    = 3'b100;
          state_d   = S_WB_I;
        end
        S_EXEC_ORI: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          alu_op    = 3'b001;
          state_d   = S_WB_I;
        end
        S_WB_I:  reg_write = 1'b1;
        S_JUMP: begin
          pc_write = 1'b1;
          pc_src   = 2'b10;
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

  assign bus.pc_write_o   = pc_write;
  assign bus.i_or_d_o     = i_or_d;
  assign bus.mem_read_o   = mem_read;
  assign bus.mem_write_o  = mem_write;
  assign bus.ir_write_o   = ir_write;
  assign bus.reg_dst_o    = reg_dst;
  assign bus.mem_to_reg_o = mem_to_reg;
  assign bus.reg_write_o  = reg_write;
  assign bus.alu_src_a_o  = alu_src_a;
  assign bus.alu_src_b_o  = alu_src_b;
  assign bus.alu_op_o     = alu_op;
  assign bus.pc_src_o     = pc_src;
  assign bus.state_o      = 4'(state_q);
  assign bus.illegal_op_o = illegal_op;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control: an instruction-level model expands each
// instruction into its expected per-cycle state/output trace, compared cycle by cycle.
module tb_multicycle_control;

  typedef struct packed {
    logic       pc_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_src;
    logic       illegal;
  } out_t;

  typedef struct {
    int         st;
    logic       rdy;
    logic [5:0] op;
  } step_t;

  localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ORI = 6'h0D, OP_LW = 6'h23, OP_SW = 6'h2B;

  logic  clk = 1'b0;
  logic  reset;
  int    n_pass = 0;
  int    n_checks = 0;
  step_t plan[$];
  out_t  got_out;

  multicycle_control_if bus ();

  multicycle_control dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign got_out = {bus.pc_write_o, bus.i_or_d_o, bus.mem_read_o, bus.mem_write_o,
                    bus.ir_write_o, bus.reg_dst_o, bus.mem_to_reg_o, bus.reg_write_o,
                    bus.alu_src_a_o, bus.alu_src_b_o, bus.alu_op_o, bus.pc_src_o,
                    bus.illegal_op_o};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
  endtask

  function automatic bit is_legal(input logic [5:0] op);
    return op == OP_R || op == OP_J || op == OP_ADDI || op == OP_ORI ||
           op == OP_LW || op == OP_SW;
  endfunction

  // Per-state output table; DECODE flags illegal opcodes, FETCH strobes follow ready.
  function automatic out_t exp_out(input int st, input logic rdy, input logic [5:0] op);
    out_t o = '0;
    case (st)
      0:  begin o.mem_read = 1; o.alu_src_b = 2'b01; o.alu_op = 3'b100;
                o.ir_write = rdy; o.pc_write = rdy; end
      1:  begin o.alu_src_b = 2'b11; o.alu_op = 3'b100; o.illegal = !is_legal(op); end
      2:  begin o.alu_src_a = 1; o.alu_src_b = 2'b10; o.alu_op = 3'b100; end
      3:  begin o.mem_read = 1; o.i_or_d = 1; end
      4:  begin o.reg_write = 1; o.mem_to_reg = 1; end
      5:  begin o.mem_write = 1; o.i_or_d = 1; end
      6:  begin o.alu_src_a = 1; o.alu_src_b = 2'b00; o.alu_op = 3'b111; end
      7:  begin o.reg_write = 1; o.reg_dst = 1; end
      8:  begin o.alu_src_a = 1; o.alu_src_b = 2'b10; o.alu_op = 3'b100; end
      9:  begin o.alu_src_a = 1; o.alu_src_b = 2'b10; o.alu_op = 3'b001; end
      10: o.reg_write = 1;
      11: begin o.pc_write = 1; o.pc_src = 2'b10; end
      default: o = '0;
    endcase
    return o;
  endfunction

  function automatic void push(input int st, input logic rdy, input logic [5:0] op);
    step_t s;
    s.st = st; s.rdy = rdy; s.op = op;
    plan.push_back(s);
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Expand one instruction into its cycle trace: fw fetch stalls, mw memory stalls.
  function automatic void plan_instr(input logic [5:0] op, input int fw, input int mw);
    for (int i = 0; i < fw; i++) push(0, 1'b0, 6'($urandom_range(0, 63)));
    push(0, 1'b1, 6'($urandom_range(0, 63)));
    push(1, rbit(), op);
    case (op)
      OP_LW: begin
        push(2, rbit(), op);
        for (int i = 0; i < mw; i++) push(3, 1'b0, op);
        push(3, 1'b1, op);
        push(4, rbit(), op);
      end
      OP_SW: begin
        push(2, rbit(), op);
        for (int i = 0; i < mw; i++) push(5, 1'b0, op);
        push(5, 1'b1, op);
      end
      OP_R:    begin push(6, rbit(), op); push(7, rbit(), op); end
      OP_ADDI: begin push(8, rbit(), op); push(10, rbit(), op); end
      OP_ORI:  begin push(9, rbit(), op); push(10, rbit(), op); end
      OP_J:    push(11, rbit(), op);
      default: ;
    endcase
  endfunction

  // Runs from just after a rising edge; inputs set, outputs sampled at the falling edge.
  task automatic run_plan();
    step_t s;
    while (plan.size() > 0) begin
      s = plan.pop_front();
      bus.mem_ready_i = s.rdy;
      bus.opcode_i    = s.op;
      @(negedge clk);
      check($sformatf("state(exp %0d)", s.st), 32'(bus.state_o), 32'(s.st));
      check($sformatf("outputs(st %0d rdy %0b op %h)", s.st, s.rdy, s.op),
            32'(got_out), 32'(exp_out(s.st, s.rdy, s.op)));
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [5:0] rand_op();
    logic [5:0] op;
    case ($urandom_range(0, 6))
      0: op = OP_R;
      1: op = OP_J;
      2: op = OP_ADDI;
      3: op = OP_ORI;
      4: op = OP_LW;
      5: op = OP_SW;
      default: begin
        op = 6'($urandom_range(0, 63));
        while (is_legal(op)) op = 6'($urandom_range(0, 63));
      end
    endcase
    return op;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.mem_ready_i = 1'b1;
    bus.opcode_i    = OP_R;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset state", 32'(bus.state_o), 32'd0);
    check("reset outputs", 32'(got_out), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Directed walk through every instruction class and the stall cases.
    plan_instr(OP_R, 0, 0);
    plan_instr(OP_LW, 0, 2);
    plan_instr(OP_SW, 1, 0);
    plan_instr(OP_ORI, 0, 0);
    plan_instr(OP_ADDI, 0, 0);
    plan_instr(OP_J, 0, 0);
    plan_instr(6'h3F, 0, 0);
    run_plan();

    // SW parked in MEM_WR, then reset asserted between clock edges.
    push(0, 1'b1, OP_R);
    push(1, 1'b1, OP_SW);
    push(2, 1'b1, OP_SW);
    push(5, 1'b0, OP_SW);
    run_plan();
    bus.mem_ready_i = 1'b0;
    @(negedge clk);
    check("mem_wr parked", 32'(bus.state_o), 32'd5);
    #2;
    reset = 1'b1;
    #1;
    check("async reset state", 32'(bus.state_o), 32'd0);
    check("async reset mem_write", 32'(bus.mem_write_o), 32'd0);
    check("async reset outputs", 32'(got_out), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int n = 0; n < 200; n++)
      plan_instr(rand_op(), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    run_plan();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control FSM for the multi-cycle MIPS datapath. It sequences each instruction through fetch, decode, execute, memory and write-back states, and drives every datapath strobe and mux select. It is the producer of the 3-bit ALU-op code that the ALU control decoder consumes. A ready handshake on memory lets fetch and load/store stall for slow memory.

## Interface
Parameters
- none. Opcodes and state encodings are fixed localparams.

Ports
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- opcode_i  in  6  instruction[31:26] from the instruction register
- mem_ready_i  in  1  memory has completed the current read or write this cycle
- pc_write_o  out  1  load the PC
- i_or_d_o  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read_o  out  1  memory read request
- mem_write_o  out  1  memory write request
- ir_write_o  out  1  load the instruction register
- reg_dst_o  out  1  write-register select: 0 = rt, 1 = rd
- mem_to_reg_o  out  1  write-back data select: 0 = ALUOut, 1 = MDR
- reg_write_o  out  1  register file write enable
- alu_src_a_o  out  1  ALU operand A select: 0 = PC, 1 = A register
- alu_src_b_o  out  2  ALU operand B select: 00 = B, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2
- alu_op_o  out  3  ALU-op code: 111 = R-type (use funct), 100 = add, 001 = or, 000 = idle
- pc_src_o  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
- state_o  out  4  current state, for debug and verification
- illegal_op_o  out  1  one-cycle pulse when the decoded opcode is unsupported

## Operation
- Supported opcodes:
  - R-type 0x00
  - ADDI 0x08
  - ORI 0x0D
  - LW 0x23
  - SW 0x2B
  - J 0x02
- State encodings: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, EXEC_R=6, WB_R=7, EXEC_ADDI=8, EXEC_ORI=9, WB_I=10, JUMP=11.
- Codes 12–15 are unreachable. If the state register ever holds one, the next state is FETCH and all outputs take their inactive values.
- Outputs are Moore (decoded from the state) except these, which are Mealy:
  - ir_write_o and pc_write_o in FETCH
  - illegal_op_o in DECODE
- Any output not listed for a state is 0.
- Per-state outputs and transitions:
  - FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=100, pc_src=00; ir_write=pc_write=mem_ready_i. Go to DECODE when mem_ready_i=1, else stay.
  - DECODE: alu_src_a=0, alu_src_b=11, alu_op=100. Next state by opcode_i:
    - LW or SW → MEM_ADDR
    - R-type → EXEC_R
    - ADDI → EXEC_ADDI
    - ORI → EXEC_ORI
    - J → JUMP
    - anything else → FETCH with illegal_op_o=1
  - MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=100. Go to MEM_RD for LW, MEM_WR for SW. opcode_i is re-sampled here; the IR is stable.
  - MEM_RD: mem_read=1, i_or_d=1. Go to MEM_WB when mem_ready_i=1, else stay.
  - MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1. Go to FETCH.
  - MEM_WR: mem_write=1, i_or_d=1. Go to FETCH when mem_ready_i=1, else stay.
  - EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=111. Go to WB_R.
  - WB_R: reg_write=1, reg_dst=1, mem_to_reg=0. Go to FETCH.
  - EXEC_ADDI: alu_src_a=1, alu_src_b=10, alu_op=100. Go to WB_I.
  - EXEC_ORI: alu_src_a=1, alu_src_b=10, alu_op=001. Go to WB_I.
  - WB_I: reg_write=1, reg_dst=0, mem_to_reg=0. Go to FETCH.
  - JUMP: pc_write=1, pc_src=10. Go to FETCH.
- Memory handshake:
  - mem_read_o or mem_write_o is held constant for as long as the FSM waits.
  - mem_ready_i is ignored in every state except FETCH, MEM_RD and MEM_WR.

## Timing
- Reset:
  - Asserting reset forces the state to FETCH immediately, without waiting for a clock edge.
  - While reset=1, all strobes (pc_write, ir_write, mem_read, mem_write, reg_write) and illegal_op_o are forced to 0, alu_op_o=000, and state_o=0.
  - The first fetch request appears in the cycle after reset deasserts.
- Reset mid-instruction aborts the instruction. No partial write-back may occur after reset is released.
- Cycle counts with zero memory wait (mem_ready_i=1 on every request):
  - LW: 5 cycles
  - SW: 4 cycles
  - R-type, ADDI, ORI: 4 cycles
  - J: 3 cycles
  - Illegal opcode: 2 cycles
- Each cycle with mem_ready_i=0 during a memory access adds exactly one cycle.
- Outputs become valid combinationally after the clock-to-Q delay of the state register. Mealy outputs follow mem_ready_i and opcode_i within the same cycle.

## Test plan
- Reset held, then released with mem_ready_i=1 and opcode_i=0x00 → state_o sequence 0,1,6,7,0. alu_op_o=111 in EXEC_R. reg_write_o=1 with reg_dst_o=1 in WB_R only.
- LW (0x23) with mem_ready_i low for 2 cycles in MEM_RD → state_o sequence 0,1,2,3,3,3,4,0. mem_read_o=1 and i_or_d_o=1 throughout MEM_RD. mem_to_reg_o=1 in MEM_WB.
- SW (0x2B) with ready delayed 1 cycle in FETCH → state_o sequence 0,0,1,2,5,0. ir_write_o and pc_write_o pulse only in the second FETCH cycle. reg_write_o never asserts.
- ORI (0x0D) then ADDI (0x08) → alu_op_o=001 in EXEC_ORI and 100 in EXEC_ADDI. alu_src_b_o=10 in both.
- J (0x02) then opcode 0x3F → JUMP state with pc_write_o=1 and pc_src_o=10. Then a DECODE cycle with illegal_op_o=1 for exactly one cycle, returning to FETCH with no reg_write_o or mem_write_o.
- Reset asserted asynchronously (mid-cycle) while in MEM_WR → state_o=0 and mem_write_o=0 immediately. After release, normal fetch resumes.
